// File: rtl/fifo_pkg.sv
// Shared helpers for the flexible FIFO: pointer wrap, count width, threshold defaults.
package fifo_pkg;

  // Default almost-empty threshold and the margin below DEPTH for almost-full.
  localparam int DEF_AEMPTY_TH    = 2;
  localparam int DEF_AFULL_MARGIN = 2;

  // Bits needed to hold an occupancy value from 0 to depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Wrapping pointer increment; explicit compare so any depth works.
  function automatic int ptr_next(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write, combinational read.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_flex.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// sticky error flags and a selectable first-word-fall-through read mode.
//
// Handshake: a write is accepted on a rising edge iff w_EN && !full, a read
// iff r_EN && !empty. Requests that are not accepted have no effect other
// than setting the sticky overflow/underflow flag. outDvalid qualifies
// data_out: in registered mode it pulses for the cycle after an accepted
// read; in FWFT mode it is high whenever the head word is present.
module fifo_flex
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = DEPTH - DEF_AFULL_MARGIN,
  parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          w_EN,
  input  logic [WIDTH-1:0]              data_in,
  input  logic                          r_EN,
  input  logic                          clr_err,
  output logic [WIDTH-1:0]              data_out,
  output logic                          outDvalid,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = cnt_width(DEPTH);

  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_flex: DEPTH must be at least 2");
  end
  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
    $error("fifo_flex: AFULL_TH must lie in 1..DEPTH");
  end
  if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
    $error("fifo_flex: AEMPTY_TH must lie in 0..DEPTH-1");
  end

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dvalid_q, dvalid_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] mem_rdata;
  logic             wr_acc, rd_acc;

  // Flags come straight from the registered count.
  assign full         = (count_q == CNT_W'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_W'(AFULL_TH));
  assign almost_empty = (count_q <= CNT_W'(AEMPTY_TH));

  assign wr_acc = w_EN && !full;
  assign rd_acc = r_EN && !empty;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc && !rst),
    .waddr_i (wptr_q),
    .wdata_i (data_in),
    .raddr_i (rptr_q),
    .rdata_o (mem_rdata)
  );

  // Next-state for pointers, count, read register and sticky errors.
  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    if (wr_acc) wptr_d = PTR_W'(ptr_next(32'(wptr_q), DEPTH));
    if (rd_acc) begin
      rptr_d   = PTR_W'(ptr_next(32'(rptr_q), DEPTH));
      dout_d   = mem_rdata;
      dvalid_d = 1'b1;
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // A new error in the same cycle as clr_err keeps the flag set.
    ovf_d = (w_EN && full)  || (ovf_q && !clr_err);
    unf_d = (r_EN && empty) || (unf_q && !clr_err);
  end

  // State registers; reset overrides any concurrent request.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign data_out  = (FWFT != 0) ? mem_rdata : dout_q;
  assign outDvalid = (FWFT != 0) ? !empty : dvalid_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_fifo_flex.sv
// Bench for fifo_flex: three configurations driven by shared random stimulus
// and compared each cycle against a queue-based behavioural model.
module tb_fifo_flex;

  logic       clk = 1'b0;
  logic       rst, w_EN, r_EN, clr_err;
  logic [7:0] data_in;

  logic [7:0] dout_o [3];
  logic       dv_o [3], full_o [3], empty_o [3], af_o [3], ae_o [3], ov_o [3], un_o [3];
  logic [2:0] cnt_a, cnt_b;
  logic [3:0] cnt_c;
  logic [3:0] cnt_o [3];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: one expected-content queue per instance.
  logic [7:0] exp_q [3][$];
  logic [7:0] exp_dout [3];
  logic       exp_dv [3], exp_ov [3], exp_un [3];

  always #5 clk = ~clk;

  assign cnt_o[0] = {1'b0, cnt_a};
  assign cnt_o[1] = {1'b0, cnt_b};
  assign cnt_o[2] = cnt_c;

  // u0: depth 5 registered read; u1: depth 5 FWFT; u2: depth 8 custom thresholds.
  fifo_flex #(.WIDTH(8), .DEPTH(5), .FWFT(0)) u0 (
    .clk(clk), .rst(rst), .w_EN(w_EN), .data_in(data_in), .r_EN(r_EN), .clr_err(clr_err),
    .data_out(dout_o[0]), .outDvalid(dv_o[0]), .full(full_o[0]), .empty(empty_o[0]),
    .almost_full(af_o[0]), .almost_empty(ae_o[0]), .count(cnt_a),
    .overflow(ov_o[0]), .underflow(un_o[0]));

  fifo_flex #(.WIDTH(8), .DEPTH(5), .FWFT(1)) u1 (
    .clk(clk), .rst(rst), .w_EN(w_EN), .data_in(data_in), .r_EN(r_EN), .clr_err(clr_err),
    .data_out(dout_o[1]), .outDvalid(dv_o[1]), .full(full_o[1]), .empty(empty_o[1]),
    .almost_full(af_o[1]), .almost_empty(ae_o[1]), .count(cnt_b),
    .overflow(ov_o[1]), .underflow(un_o[1]));

  fifo_flex #(.WIDTH(8), .DEPTH(8), .FWFT(0), .AFULL_TH(6), .AEMPTY_TH(1)) u2 (
    .clk(clk), .rst(rst), .w_EN(w_EN), .data_in(data_in), .r_EN(r_EN), .clr_err(clr_err),
    .data_out(dout_o[2]), .outDvalid(dv_o[2]), .full(full_o[2]), .empty(empty_o[2]),
    .almost_full(af_o[2]), .almost_empty(ae_o[2]), .count(cnt_c),
    .overflow(ov_o[2]), .underflow(un_o[2]));

  function automatic int dep_of(input int k);
    return (k == 2) ? 8 : 5;
  endfunction
  function automatic int aft_of(input int k);
    return (k == 2) ? 6 : 3;
  endfunction
  function automatic int aet_of(input int k);
    return (k == 2) ? 1 : 2;
  endfunction
  function automatic bit fwft_of(input int k);
    return (k == 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      int sz;
      sz = exp_q[k].size();
      chk($sformatf("u%0d.count", k), 32'(cnt_o[k]), sz);
      chk($sformatf("u%0d.full", k), 32'(full_o[k]), 32'(sz == dep_of(k)));
      chk($sformatf("u%0d.empty", k), 32'(empty_o[k]), 32'(sz == 0));
      chk($sformatf("u%0d.almost_full", k), 32'(af_o[k]), 32'(sz >= aft_of(k)));
      chk($sformatf("u%0d.almost_empty", k), 32'(ae_o[k]), 32'(sz <= aet_of(k)));
      chk($sformatf("u%0d.overflow", k), 32'(ov_o[k]), 32'(exp_ov[k]));
      chk($sformatf("u%0d.underflow", k), 32'(un_o[k]), 32'(exp_un[k]));
      if (fwft_of(k)) begin
        chk($sformatf("u%0d.outDvalid", k), 32'(dv_o[k]), 32'(sz != 0));
        if (sz != 0) chk($sformatf("u%0d.data_out", k), 32'(dout_o[k]), 32'(exp_q[k][0]));
      end else begin
        chk($sformatf("u%0d.outDvalid", k), 32'(dv_o[k]), 32'(exp_dv[k]));
        chk($sformatf("u%0d.data_out", k), 32'(dout_o[k]), 32'(exp_dout[k]));
      end
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int         sz;
      bit         f, e;
      logic [7:0] head;
      sz = exp_q[k].size();
      f  = (sz == dep_of(k));
      e  = (sz == 0);
      if (rst) begin
        exp_q[k].delete();
        exp_dout[k] = 8'h00;
        exp_dv[k]   = 1'b0;
        exp_ov[k]   = 1'b0;
        exp_un[k]   = 1'b0;
      end else begin
        exp_ov[k] = (w_EN && f) || (exp_ov[k] && !clr_err);
        exp_un[k] = (r_EN && e) || (exp_un[k] && !clr_err);
        exp_dv[k] = 1'b0;
        if (r_EN && !e) begin
          head = exp_q[k].pop_front();
          if (!fwft_of(k)) begin
            exp_dout[k] = head;
            exp_dv[k]   = 1'b1;
          end
        end
        if (w_EN && !f) exp_q[k].push_back(data_in);
      end
    end
  endtask

  task automatic step(input logic r_, input logic w, input logic r, input logic c,
                      input logic [7:0] d);
    check_all();
    rst = r_; w_EN = w; r_EN = r; clr_err = c; data_in = d;
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n, input int pw, input int pr, input int pc, input int prst,
                     input bit seq);
    for (int i = 0; i < n; i++) begin
      step(32'($urandom_range(99)) < prst, 32'($urandom_range(99)) < pw,
           32'($urandom_range(99)) < pr, 32'($urandom_range(99)) < pc,
           seq ? 8'(8'hA0 + i) : 8'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1; w_EN = 1'b0; r_EN = 1'b0; clr_err = 1'b0; data_in = 8'h00;
    model_step();
    @(posedge clk);
    @(negedge clk);
    // Fill with A0.. past full, then drain past empty.
    run(10, 100, 0, 0, 0, 1);
    run(12, 0, 100, 0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    // Simultaneous requests while empty, then mixed traffic.
    run(6, 100, 100, 0, 0, 1);
    run(300, 50, 50, 5, 2, 0);
    run(40, 75, 30, 3, 0, 0);
    run(40, 30, 75, 3, 0, 0);
    run(80, 60, 60, 5, 0, 0);
    // Reset mid-operation with a concurrent write, then a fresh round trip.
    run(12, 0, 100, 0, 0, 0);
    run(3, 100, 0, 0, 0, 1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h77);
    run(4, 100, 0, 0, 0, 1);
    run(6, 0, 100, 0, 0, 0);
    check_all();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_flex.md
Name: fifo_flex

Overview:
Parametrised synchronous single-clock FIFO, successor to the basic fixed-width FIFO.
- Adds arbitrary (non-power-of-two) depth, generic data width and an occupancy count.
- Adds programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode.
- Used as the standard buffering element between streaming stages.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries (>=2, any integer)
FWFT, 0, 0 = registered read (1-cycle latency); 1 = first-word-fall-through
AFULL_TH, DEPTH-2, almost_full asserted when count >= AFULL_TH (1..DEPTH)
AEMPTY_TH, 2, almost_empty asserted when count <= AEMPTY_TH (0..DEPTH-1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
w_EN  in  1  write request
data_in  in  WIDTH  write data
r_EN  in  1  read request (FWFT=1: pop/acknowledge of head word)
clr_err  in  1  clears overflow/underflow
data_out  out  WIDTH  read data
outDvalid  out  1  data_out valid
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AFULL_TH
almost_empty  out  1  count <= AEMPTY_TH
count  out  CNT_W  occupancy, CNT_W = $clog2(DEPTH+1)
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Clock and reset: one clock (clk); synchronous active-high reset (rst).
- Reset values: wptr=rptr=0, count=0, data_out=0, outDvalid=0, overflow=underflow=0. Memory array is not reset.
  - rst has priority over every other input in the same cycle; a w_EN/r_EN coincident with rst is discarded.
  - Reset mid-operation discards all contents.
- Write: accepted iff w_EN && !full.
  - Stores data_in at wptr.
  - wptr advances; wraps DEPTH-1 -> 0 by explicit compare (no power-of-two assumption).
- Read: accepted iff r_EN && !empty.
  - rptr advances with the same wrap rule.
- count register update:
  - +1 on accepted write only.
  - -1 on accepted read only.
  - Unchanged when both or neither are accepted.
- Flags: full, empty, almost_full and almost_empty are decoded combinationally from the count register, so they reflect operations from the previous edge.
- Simultaneous w_EN && r_EN:
  - count in 1..DEPTH-1: both accepted, count unchanged.
  - full: read accepted, write rejected (no bypass), overflow set.
  - empty: write accepted, read rejected (no bypass), underflow set.
- FWFT=0:
  - Accepted read loads data_out from mem[rptr] on that edge; outDvalid=1 for exactly the following cycle.
  - With no accepted read, outDvalid=0 and data_out holds its last value.
- FWFT=1:
  - data_out = mem[rptr] (combinational read); outDvalid = !empty.
  - A write into an empty FIFO is visible on data_out the cycle after the write edge.
  - An accepted r_EN pops the head word; the next entry appears after that edge.
- Errors:
  - overflow set on w_EN && full; underflow set on r_EN && empty.
  - Both hold until clr_err. If set and clear occur in the same cycle, set wins.
- Elaboration: $error if DEPTH<2, AFULL_TH is outside 1..DEPTH, or AEMPTY_TH is outside 0..DEPTH-1.

Decomposition:
- Package fifo_pkg holds:
  - Function ptr_next(ptr, depth) (wrap increment).
  - Function cnt_width(depth) = $clog2(depth+1).
  - Localparam defaults for thresholds.
- Sub-module fifo_mem: simple dual-port register array.
  - Synchronous write port (we, waddr, wdata).
  - Combinational read (raddr -> rdata).
  - Parametrised by WIDTH and DEPTH.
- fifo_flex holds pointers, count, flags and output register.

Test Plan:
1. DEPTH=5, FWFT=0: write 0xA0..0xA4 -> full=1, count=5. Extra write -> overflow=1, no data change. Read 5 -> data_out A0..A4, each one cycle after r_EN with a 1-cycle outDvalid pulse; then empty=1, count=0.
2. Wrap: DEPTH=5, 12 words with interleaved write/read bursts -> output order preserved across pointer wraps 4->0, count never exceeds 5.
3. Simultaneous w_EN+r_EN:
   - count=3 -> count stays 3.
   - full -> count=4, overflow=1.
   - empty -> count=1, underflow=1, outDvalid=0.
4. FWFT=1: write 0x55 into empty -> next cycle outDvalid=1, data_out=0x55 without r_EN. Write 0x66, then r_EN -> data_out=0x66. r_EN again -> outDvalid=0.
5. Thresholds: DEPTH=8, AFULL_TH=6, AEMPTY_TH=1, sweep count 0->8->0 -> almost_empty=1 at count<=1, almost_full=1 at count>=6. Then assert clr_err with no concurrent error -> overflow/underflow clear.
6. Reset mid-operation: count=3, assert rst one cycle with w_EN=1 -> count=0, empty=1, outDvalid=0, data_out=0, errors 0. Next write/read round-trips correctly.
